// File: rtl/polar_peak_detect.sv
// Per-frame peak finder that sits after the CORDIC rectangular-to-polar converter.
// It finds the strongest bin at or above a threshold and reports it once per complete frame.
module polar_peak_detect #(
   parameter int WIDTH_XY = 32,
   parameter int WIDTH_PH = 32,
   parameter int NBINS    = 1024,
   parameter int BIN_LO   = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_vld,
   input  logic                       i_sof,
   input  logic [WIDTH_XY-1:0]        i_mag,
   input  logic [WIDTH_PH-1:0]        i_phase,
   input  logic [WIDTH_XY-1:0]        i_thr,
   output logic                       o_vld,
   output logic                       o_found,
   output logic [$clog2(NBINS)-1:0]   o_bin,
   output logic [WIDTH_XY-1:0]        o_mag,
   output logic [WIDTH_PH-1:0]        o_phase,
   output logic [15:0]                o_frame,
   output logic                       o_err
);

   localparam int BW = $clog2(NBINS);
   localparam int CW = BW + 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(NBINS - 1);
   localparam logic [CW-1:0] LO_IDX   = CW'(BIN_LO);

   typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

   state_t              state;
   state_t              state_nxt;
   logic                start;
   logic                take;
   logic                last;
   logic                abort;

   logic [CW-1:0]       cnt;
   logic [WIDTH_XY-1:0] thr_r;
   logic                best_vld;
   logic [BW-1:0]       best_bin;
   logic [WIDTH_XY-1:0] best_mag;
   logic [WIDTH_PH-1:0] best_phase;

   logic [WIDTH_XY-1:0] mag_eff;
   logic [CW-1:0]       cur_idx;
   logic [WIDTH_XY-1:0] cur_thr;
   logic                cur_bv;
   logic                cand;
   logic                nb_vld;
   logic [BW-1:0]       nb_bin;
   logic [WIDTH_XY-1:0] nb_mag;
   logic [WIDTH_PH-1:0] nb_phase;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // A start-of-frame wins over everything: in ACCUM it aborts the frame in flight.
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      take      = 1'b0;
      last      = 1'b0;
      abort     = 1'b0;
      case (state)
         IDLE: begin
            if (i_vld && i_sof) begin
               start     = 1'b1;
               state_nxt = ACCUM;
            end
         end
         ACCUM: begin
            if (i_vld) begin
               if (i_sof) begin
                  start = 1'b1;
                  abort = 1'b1;
               end else begin
                  take = 1'b1;
                  if (cnt == LAST_IDX) begin
                     last      = 1'b1;
                     state_nxt = REPORT;
                  end
               end
            end
         end
         REPORT: begin
            if (i_vld && i_sof) begin
               start     = 1'b1;
               state_nxt = ACCUM;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A new frame evaluates its bin 0 against the incoming threshold with an empty best.
   always_comb begin
      mag_eff  = i_mag[WIDTH_XY-1] ? '0 : i_mag;
      cur_idx  = start ? '0 : cnt;
      cur_thr  = start ? i_thr : thr_r;
      cur_bv   = start ? 1'b0 : best_vld;
      cand     = (start || take) && (cur_idx >= LO_IDX) && (mag_eff >= cur_thr) &&
                 (!cur_bv || (mag_eff > best_mag));
      nb_vld   = cur_bv;
      nb_bin   = start ? '0 : best_bin;
      nb_mag   = start ? '0 : best_mag;
      nb_phase = start ? '0 : best_phase;
      if (cand) begin
         nb_vld   = 1'b1;
         nb_bin   = cur_idx[BW-1:0];
         nb_mag   = mag_eff;
         nb_phase = i_phase;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         thr_r      <= '0;
         best_vld   <= 1'b0;
         best_bin   <= '0;
         best_mag   <= '0;
         best_phase <= '0;
      end else begin
         if (start) begin
            cnt   <= CW'(1);
            thr_r <= i_thr;
         end else if (take) begin
            cnt <= cnt + CW'(1);
         end
         if (start || take) begin
            best_vld   <= nb_vld;
            best_bin   <= nb_bin;
            best_mag   <= nb_mag;
            best_phase <= nb_phase;
         end
      end
   end

   // The report includes the last bin's own candidacy, so it is loaded from the updated best.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_vld   <= 1'b0;
         o_found <= 1'b0;
         o_bin   <= '0;
         o_mag   <= '0;
         o_phase <= '0;
         o_frame <= '0;
         o_err   <= 1'b0;
      end else begin
         o_vld <= last;
         o_err <= abort;
         if (last) begin
            o_found <= nb_vld;
            o_bin   <= nb_vld ? nb_bin : '0;
            o_mag   <= nb_vld ? nb_mag : '0;
            o_phase <= nb_vld ? nb_phase : '0;
            o_frame <= o_frame + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_polar_peak_detect.sv
// Self-checking bench for polar_peak_detect with 8-bin frames.
// The expected peak for each frame comes from a plain loop over the stored samples.
module tb_polar_peak_detect;

   localparam int NB  = 8;
   localparam int BLO = 1;

   logic        clk;
   logic        rst_n;
   logic        i_vld;
   logic        i_sof;
   logic [31:0] i_mag;
   logic [31:0] i_phase;
   logic [31:0] i_thr;
   logic        o_vld;
   logic        o_found;
   logic [2:0]  o_bin;
   logic [31:0] o_mag;
   logic [31:0] o_phase;
   logic [15:0] o_frame;
   logic        o_err;

   int          nAsserts;
   int          nFail;

   logic [31:0] fm [NB];
   logic [31:0] fp [NB];
   logic [31:0] fthr;

   logic        expFound;
   logic [2:0]  expBin;
   logic [31:0] expMag;
   logic [31:0] expPh;
   logic [15:0] expFrame;

   polar_peak_detect #(
      .WIDTH_XY (32),
      .WIDTH_PH (32),
      .NBINS    (NB),
      .BIN_LO   (BLO)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_vld   (i_vld),
      .i_sof   (i_sof),
      .i_mag   (i_mag),
      .i_phase (i_phase),
      .i_thr   (i_thr),
      .o_vld   (o_vld),
      .o_found (o_found),
      .o_bin   (o_bin),
      .o_mag   (o_mag),
      .o_phase (o_phase),
      .o_frame (o_frame),
      .o_err   (o_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic v, input logic s, input logic [31:0] m,
                                input logic [31:0] p, input logic [31:0] t);
      i_vld   = v;
      i_sof   = s;
      i_mag   = m;
      i_phase = p;
      i_thr   = t;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Peak rule straight from the definition: eligible bins, clipped magnitude, first strict max.
   task automatic computePeak();
      logic [31:0] eff;
      expFound = 1'b0;
      expBin   = '0;
      expMag   = '0;
      expPh    = '0;
      for (int b = BLO; b < NB; b++) begin
         eff = fm[b][31] ? 32'd0 : fm[b];
         if (eff >= fthr && (!expFound || eff > expMag)) begin
            expFound = 1'b1;
            expBin   = 3'(b);
            expMag   = eff;
            expPh    = fp[b];
         end
      end
   endtask

   task automatic checkQuiet(input logic expErr);
      checkOutput("quiet_vld", {63'd0, o_vld}, 64'd0);
      checkOutput("quiet_err", {63'd0, o_err}, {63'd0, expErr});
   endtask

   task automatic checkReport(input string tag);
      expFrame = expFrame + 16'd1;
      checkOutput({tag, "_vld"},   {63'd0, o_vld},   64'd1);
      checkOutput({tag, "_found"}, {63'd0, o_found}, {63'd0, expFound});
      checkOutput({tag, "_bin"},   {61'd0, o_bin},   {61'd0, expBin});
      checkOutput({tag, "_mag"},   {32'd0, o_mag},   {32'd0, expMag});
      checkOutput({tag, "_phase"}, {32'd0, o_phase}, {32'd0, expPh});
      checkOutput({tag, "_frame"}, {48'd0, o_frame}, {48'd0, expFrame});
      checkOutput({tag, "_err"},   {63'd0, o_err},   64'd0);
   endtask

   task automatic sendFrame(input int n, input bit tickFirst, input bit errAfterSof, input bit gaps);
      logic pendErr;
      pendErr = 1'b0;
      computePeak();
      for (int b = 0; b < n; b++) begin
         if (b > 0 || tickFirst) tick();
         if (b > 0) begin
            checkQuiet(pendErr);
            pendErr = 1'b0;
         end
         applyStimulus(1'b1, b == 0, fm[b], fp[b], (b == 0) ? fthr : $urandom);
         if (b == 0) pendErr = errAfterSof;
         if (gaps && b < n - 1) begin
            repeat ($urandom_range(0, 2)) begin
               tick();
               checkQuiet(pendErr);
               pendErr = 1'b0;
               applyStimulus(1'b0, 1'($urandom), $urandom, $urandom, $urandom);
            end
         end
      end
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic randomFrame();
      int r;
      for (int b = 0; b < NB; b++) begin
         r = $urandom_range(0, 9);
         if (r == 0)      fm[b] = -32'($urandom_range(1, 32'h4000_0000));
         else if (r == 1) fm[b] = $urandom_range(0, 32'h7FFF_FFFF);
         else             fm[b] = $urandom_range(0, 60);
         fp[b] = $urandom;
      end
      r = $urandom_range(0, 7);
      if (r == 0)      fthr = 32'hFFFF_FFF0;
      else if (r == 1) fthr = 32'd0;
      else             fthr = $urandom_range(0, 50);
   endtask

   initial begin
      bit bb;
      nAsserts = 0;
      nFail    = 0;
      expFrame = '0;
      rst_n    = 1'b0;
      idle();
      repeat (3) tick();
      checkOutput("rst_vld",   {63'd0, o_vld},   64'd0);
      checkOutput("rst_found", {63'd0, o_found}, 64'd0);
      checkOutput("rst_bin",   {61'd0, o_bin},   64'd0);
      checkOutput("rst_mag",   {32'd0, o_mag},   64'd0);
      checkOutput("rst_phase", {32'd0, o_phase}, 64'd0);
      checkOutput("rst_frame", {48'd0, o_frame}, 64'd0);
      checkOutput("rst_err",   {63'd0, o_err},   64'd0);
      rst_n = 1'b1;

      $display("[TB] stray strobes in IDLE, then basic peak frame");
      tick();
      applyStimulus(1'b1, 1'b0, 32'd999, 32'd1, 32'd0);
      tick();
      tick();
      checkQuiet(1'b0);
      idle();
      fthr = 32'd10;
      fm = '{32'd50, 32'd3, 32'd7, 32'd40, 32'd90, 32'd12, 32'd90, 32'd5};
      for (int b = 0; b < NB; b++) fp[b] = 32'(b) * 32'h0040_0000;
      sendFrame(NB, 1'b1, 1'b0, 1'b0);
      tick();
      checkReport("basic");
      applyStimulus(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd7, 32'd0);
      tick();
      checkQuiet(1'b0);
      checkOutput("hold_bin", {61'd0, o_bin}, 64'd4);
      checkOutput("hold_mag", {32'd0, o_mag}, 64'd90);
      idle();

      $display("[TB] threshold above every magnitude");
      fthr = 32'd100;
      for (int b = 0; b < NB; b++) begin
         fm[b] = $urandom_range(0, 99);
         fp[b] = $urandom;
      end
      sendFrame(NB, 1'b1, 1'b0, 1'b0);
      tick();
      checkReport("nofind");
      idle();

      $display("[TB] aborted partial frame followed by full frame");
      fthr = 32'd10;
      fm = '{32'd80, 32'd99, 32'd95, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
      sendFrame(3, 1'b1, 1'b0, 1'b0);
      fm = '{32'd10, 32'd20, 32'd5, 32'd30, 32'd60, 32'd77, 32'd12, 32'd3};
      for (int b = 0; b < NB; b++) fp[b] = $urandom;
      sendFrame(NB, 1'b1, 1'b1, 1'b0);
      tick();
      checkReport("abort");
      idle();

      $display("[TB] back-to-back frames");
      randomFrame();
      sendFrame(NB, 1'b1, 1'b0, 1'b0);
      tick();
      checkReport("b2b_a");
      randomFrame();
      sendFrame(NB, 1'b0, 1'b0, 1'b0);
      tick();
      checkReport("b2b_b");
      idle();

      $display("[TB] negative magnitude, zero threshold");
      fthr = 32'd0;
      fm = '{32'd0, 32'd0, 32'd0, -32'sd5, 32'd0, 32'd0, 32'd0, 32'd0};
      for (int b = 0; b < NB; b++) fp[b] = $urandom;
      sendFrame(NB, 1'b1, 1'b0, 1'b0);
      tick();
      checkReport("negmag");
      checkOutput("negmag_bin1", {61'd0, o_bin}, 64'd1);
      idle();

      $display("[TB] reset in the middle of a frame");
      randomFrame();
      sendFrame(5, 1'b1, 1'b0, 1'b0);
      tick();
      rst_n = 1'b0;
      idle();
      #1;
      checkOutput("midrst_frame", {48'd0, o_frame}, 64'd0);
      checkOutput("midrst_found", {63'd0, o_found}, 64'd0);
      checkOutput("midrst_mag",   {32'd0, o_mag},   64'd0);
      tick();
      tick();
      checkQuiet(1'b0);
      rst_n = 1'b1;
      expFrame = '0;
      tick();
      checkQuiet(1'b0);
      randomFrame();
      sendFrame(NB, 1'b1, 1'b0, 1'b0);
      tick();
      checkReport("postrst");
      idle();

      $display("[TB] randomized frames");
      bb = 1'b0;
      for (int f = 0; f < 12; f++) begin
         bit ab;
         bit gp;
         ab = ($urandom_range(0, 2) == 0);
         gp = 1'($urandom);
         randomFrame();
         if (ab) begin
            sendFrame($urandom_range(1, NB - 1), !bb, 1'b0, gp);
            randomFrame();
            sendFrame(NB, 1'b1, 1'b1, gp);
         end else begin
            sendFrame(NB, !bb, 1'b0, gp);
         end
         tick();
         checkReport("rand");
         bb = 1'($urandom);
         if (!bb) idle();
      end
      tick();
      idle();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
      $finish;
   end

endmodule
